region_allocator: RTL and testbench
===================================

REGION_ALLOCATOR -- requirements
Module: region_allocator

Interface
REQ-001 Parameter: ADDR_SIZE, 23, address width of all region bounds.
REQ-002 Parameter: NUM_POOLS, 2, number of independent memory pools, e.g. SDRAM and M9K.
REQ-003 Parameter: LEN_W, 32, width of requested length.
REQ-004 Parameter: HDR_WORDS, 3, header overhead added when req_hdr=1.
REQ-005 Parameter: STACK_DEPTH, 8, depth of the allocation-undo stack, power of two.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 Port: clk  input  1  sole clock, rising edge.
REQ-008 Port: rst  input  1  synchronous active-high reset.
REQ-009 Port: cfg_we, cfg_pool, cfg_base, cfg_limit  input  1/clog2(NUM_POOLS)/ADDR_SIZE/ADDR_SIZE  pool configuration write.
REQ-010 Port: req_valid, req_pool, req_len, req_hdr  input  1/clog2(NUM_POOLS)/LEN_W/1  allocation request.
REQ-011 Port: req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-012 Port: rsp_valid, rsp_begin, rsp_end, rsp_err  output  1/ADDR_SIZE/ADDR_SIZE/1  allocation result; rsp_end is exclusive.
REQ-013 Port: rsp_ready  input  1  result consumed when rsp_valid and rsp_ready are both high.
REQ-014 Port: free_valid  input  1  undo the most recent surviving allocation.
REQ-015 Port: free_err  output  1  one-cycle pulse when free_valid arrives with the stack empty.
REQ-016 Port: stat_pool  input  clog2(NUM_POOLS)  selects the pool reported on stat_avail.
REQ-017 Port: stat_avail  output  ADDR_SIZE  combinational next-free address of stat_pool.

Function
REQ-018 Per-pool state: base, limit, avail. States: IDLE, CALC, RESP.
REQ-019 req_ready SHALL equal (state==IDLE) && !cfg_we && !free_valid; IDLE priority is cfg_we, then free_valid, then request.
REQ-020 A cfg_we in IDLE SHALL set base=limit=cfg_base/cfg_limit and avail=cfg_base for cfg_pool, and flush the undo stack; cfg_we outside IDLE SHALL be ignored.
REQ-021 An accepted request in cycle t SHALL be latched and the FSM SHALL enter CALC; CALC SHALL be in t+1 and rsp_valid SHALL rise in t+2 (RESP).
REQ-022 CALC: total = req_len + (req_hdr ? HDR_WORDS : 0), computed at max(LEN_W,ADDR_SIZE)+1 bits without truncation; end = avail + total at the same width.
REQ-023 rsp_err=1 if req_pool >= NUM_POOLS, total==0, or end > limit; on error rsp_begin=rsp_end=avail of the pool (0 for an invalid pool) and no state changes.
REQ-024 Success: rsp_begin=avail, rsp_end=end[ADDR_SIZE-1:0], avail<=end, push {pool, old avail} onto the undo stack.
REQ-025 end == limit SHALL succeed (the pool becomes exactly full).
REQ-026 If the stack is full, the push SHALL overwrite the oldest entry; depth stays STACK_DEPTH.
REQ-027 RESP SHALL hold rsp_valid and the data stable until rsp_ready, then return to IDLE in the next cycle; rsp_ready in the rsp_valid cycle gives a 3-cycle request-to-request turnaround.
REQ-028 free_valid in IDLE with a non-empty stack SHALL pop the top entry and restore that pool's avail to the stored value in the same edge; with an empty stack free_err pulses for one cycle and no state changes.
REQ-029 free_valid outside IDLE SHALL be ignored; no free_err.
REQ-030 Frees SHALL be strictly LIFO across all pools.

Reset
REQ-031 On rst: state=IDLE; all base/limit/avail=0; stack empty; rsp_valid=0, rsp_err=0, rsp_begin=rsp_end=0, free_err=0; req_ready=1 from the first cycle after rst falls.
REQ-032 rst mid-transaction SHALL discard the pending request and result without a response.

Verification
REQ-033 cfg pool0 base=0 limit=0x400000; request len=10 hdr=1 -> rsp in t+2: begin=0 end=13 err=0; stat_avail=13.
REQ-034 cfg pool1 base=0x400000 limit=0x400010; request len=16 hdr=0 -> end=0x400010 err=0; next request len=1 -> err=1, begin=end=0x400010.
REQ-035 Two allocations on pool0 (len 5, len 7), then two frees -> avail 12 -> 5 -> 0; a third free -> free_err pulse, avail stays 0.
REQ-036 Nine successive allocations with STACK_DEPTH=8, then nine frees -> eight restores, ninth gives free_err; avail = end of the first allocation.
REQ-037 cfg_we, free_valid and req_valid asserted together in IDLE -> only cfg applied, stack flushed, req_ready=0 that cycle; hold rsp_ready=0 for 5 cycles -> rsp held stable.
REQ-038 Request with req_pool=NUM_POOLS -> err=1 with begin=end=0; rst asserted in CALC -> no rsp_valid, all outputs at reset values.

Source files
------------

// File: rtl/region_allocator.sv
// Bump allocator over NUM_POOLS address pools with a shared LIFO undo stack.
// Request-to-response latency is 2 cycles; a response is held until rsp_ready.
module region_allocator #(
   parameter int ADDR_SIZE   = 23,
   parameter int NUM_POOLS   = 2,
   parameter int LEN_W       = 32,
   parameter int HDR_WORDS   = 3,
   parameter int STACK_DEPTH = 8,
   localparam int PW = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [PW-1:0]        cfg_pool,
   input  logic [ADDR_SIZE-1:0] cfg_base,
   input  logic [ADDR_SIZE-1:0] cfg_limit,
   input  logic                 req_valid,
   input  logic [PW-1:0]        req_pool,
   input  logic [LEN_W-1:0]     req_len,
   input  logic                 req_hdr,
   output logic                 req_ready,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_begin,
   output logic [ADDR_SIZE-1:0] rsp_end,
   output logic                 rsp_err,
   input  logic                 rsp_ready,
   input  logic                 free_valid,
   output logic                 free_err,
   input  logic [PW-1:0]        stat_pool,
   output logic [ADDR_SIZE-1:0] stat_avail
);

   localparam int CW = ((LEN_W > ADDR_SIZE) ? LEN_W : ADDR_SIZE) + 1;
   localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t               state;
   logic [ADDR_SIZE-1:0] limit_q [NUM_POOLS];
   logic [ADDR_SIZE-1:0] avail_q [NUM_POOLS];
   logic [PW-1:0]        stk_pool [STACK_DEPTH];
   logic [ADDR_SIZE-1:0] stk_addr [STACK_DEPTH];
   logic [SW-1:0]        sp;
   logic [SW:0]          cnt;
   logic [PW-1:0]        lat_pool;
   logic [LEN_W-1:0]     lat_len;
   logic                 lat_hdr;

   logic                 pool_ok, cfg_ok, stat_ok;
   logic [PW-1:0]        pidx;
   logic [ADDR_SIZE-1:0] cur_avail;
   logic [CW-1:0]        total, end_sum;
   logic                 calc_err;
   logic [SW-1:0]        top;

   assign pool_ok = {1'b0, lat_pool}  < (PW+1)'(NUM_POOLS);
   assign cfg_ok  = {1'b0, cfg_pool}  < (PW+1)'(NUM_POOLS);
   assign stat_ok = {1'b0, stat_pool} < (PW+1)'(NUM_POOLS);
   assign pidx    = pool_ok ? lat_pool : '0;
   assign top     = sp - 1'b1;

   assign req_ready  = (state == IDLE) && !cfg_we && !free_valid;
   assign stat_avail = stat_ok ? avail_q[stat_pool] : '0;

   // Sum is one bit wider than either operand so a huge length can never wrap under the limit.
   always_comb begin
      cur_avail = pool_ok ? avail_q[pidx] : '0;
      total     = CW'(lat_len) + (lat_hdr ? CW'(HDR_WORDS) : CW'(0));
      end_sum   = CW'(cur_avail) + total;
      calc_err  = !pool_ok || (total == '0) || (end_sum > CW'(limit_q[pidx]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sp        <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_begin <= '0;
         rsp_end   <= '0;
         free_err  <= 1'b0;
         lat_pool  <= '0;
         lat_len   <= '0;
         lat_hdr   <= 1'b0;
         for (int i = 0; i < NUM_POOLS; i++) begin
            limit_q[i] <= '0;
            avail_q[i] <= '0;
         end
      end else begin
         free_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_we) begin
                  if (cfg_ok) begin
                     limit_q[cfg_pool] <= cfg_limit;
                     avail_q[cfg_pool] <= cfg_base;
                  end
                  sp  <= '0;
                  cnt <= '0;
               end else if (free_valid) begin
                  if (cnt == '0) begin
                     free_err <= 1'b1;
                  end else begin
                     avail_q[stk_pool[top]] <= stk_addr[top];
                     sp  <= top;
                     cnt <= cnt - 1'b1;
                  end
               end else if (req_valid) begin
                  lat_pool <= req_pool;
                  lat_len  <= req_len;
                  lat_hdr  <= req_hdr;
                  state    <= CALC;
               end
            end
            CALC: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= calc_err;
               rsp_begin <= cur_avail;
               if (calc_err) begin
                  rsp_end <= cur_avail;
               end else begin
                  rsp_end        <= end_sum[ADDR_SIZE-1:0];
                  avail_q[pidx]  <= end_sum[ADDR_SIZE-1:0];
                  // Circular stack: when full, the write lands on the oldest entry.
                  stk_pool[sp]   <= pidx;
                  stk_addr[sp]   <= cur_avail;
                  sp             <= sp + 1'b1;
                  if (cnt != (SW+1)'(STACK_DEPTH))
                     cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_region_allocator.sv
// Randomised and directed bench for region_allocator against a queue-based pool model.
module tb_region_allocator;
   localparam int AW = 23;
   localparam int NP = 3;
   localparam int LW = 32;
   localparam int HW = 3;
   localparam int SD = 8;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [PW-1:0] cfg_pool = '0;
   logic [AW-1:0] cfg_base = '0;
   logic [AW-1:0] cfg_limit = '0;
   logic          req_valid = 1'b0;
   logic [PW-1:0] req_pool = '0;
   logic [LW-1:0] req_len = '0;
   logic          req_hdr = 1'b0;
   logic          req_ready;
   logic          rsp_valid;
   logic [AW-1:0] rsp_begin;
   logic [AW-1:0] rsp_end;
   logic          rsp_err;
   logic          rsp_ready = 1'b0;
   logic          free_valid = 1'b0;
   logic          free_err;
   logic [PW-1:0] stat_pool = '0;
   logic [AW-1:0] stat_avail;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int              pool;
      longint unsigned addr;
   } ent_t;

   longint unsigned m_lim [NP];
   longint unsigned m_av  [NP];
   ent_t            stk   [$];

   region_allocator #(
      .ADDR_SIZE(AW), .NUM_POOLS(NP), .LEN_W(LW), .HDR_WORDS(HW), .STACK_DEPTH(SD)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_pool(cfg_pool), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
      .req_valid(req_valid), .req_pool(req_pool), .req_len(req_len), .req_hdr(req_hdr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_begin(rsp_begin), .rsp_end(rsp_end), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready),
      .free_valid(free_valid), .free_err(free_err),
      .stat_pool(stat_pool), .stat_avail(stat_avail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_lim[i] = 0;
         m_av[i]  = 0;
      end
      stk.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_err"},   rsp_err, 0);
      chk({tag, "_rsp_begin"}, rsp_begin, 0);
      chk({tag, "_rsp_end"},   rsp_end, 0);
      chk({tag, "_free_err"},  free_err, 0);
      chk({tag, "_req_ready"}, req_ready, 1);
   endtask

   task automatic do_cfg(input int p, input longint unsigned b, input longint unsigned l);
      @(negedge clk);
      cfg_we = 1'b1; cfg_pool = PW'(p); cfg_base = AW'(b); cfg_limit = AW'(l);
      #1 chk("cfg_req_ready", req_ready, 0);
      @(negedge clk);
      cfg_we = 1'b0;
      m_lim[p] = l; m_av[p] = b; stk.delete();
      stat_pool = PW'(p);
      #1 chk("cfg_avail", stat_avail, b);
   endtask

   task automatic do_alloc(input int p, input longint unsigned len, input bit hdr, input int hold);
      longint unsigned tot, e, xb, xe;
      bit xerr;
      tot = len + (hdr ? HW : 0);
      if (p >= NP) begin
         xerr = 1; xb = 0; xe = 0;
      end else begin
         e = m_av[p] + tot;
         xb = m_av[p];
         if (tot == 0 || e > m_lim[p]) begin xerr = 1; xe = m_av[p]; end
         else begin xerr = 0; xe = e; end
      end
      @(negedge clk);
      req_valid = 1'b1; req_pool = PW'(p); req_len = LW'(len); req_hdr = hdr;
      #1 chk("req_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("calc_no_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err",   rsp_err, xerr);
      chk("rsp_begin", rsp_begin, xb);
      chk("rsp_end",   rsp_end, xe);
      if (!xerr) begin
         stk.push_back('{p, m_av[p]});
         if (stk.size() > SD) stk.delete(0);
         m_av[p] = xe;
      end
      stat_pool = PW'(p);
      #1 chk("stat_avail", stat_avail, (p < NP) ? m_av[p] : 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_begin", rsp_begin, xb);
         chk("hold_end",   rsp_end, xe);
         chk("hold_err",   rsp_err, xerr);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("idle_ready", req_ready, 1);
   endtask

   task automatic do_free();
      bit   empty;
      ent_t x;
      empty = (stk.size() == 0);
      @(negedge clk);
      free_valid = 1'b1;
      #1 chk("free_req_ready", req_ready, 0);
      @(negedge clk);
      free_valid = 1'b0;
      chk("free_err", free_err, empty);
      if (!empty) begin
         x = stk.pop_back();
         m_av[x.pool] = x.addr;
         stat_pool = PW'(x.pool);
         #1 chk("free_restore", stat_avail, x.addr);
      end
      @(negedge clk);
      chk("free_err_pulse", free_err, 0);
   endtask

   initial begin
      longint unsigned first_end, b;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check_reset_outputs("reset");
      for (int p = 0; p < NP; p++) begin
         stat_pool = PW'(p);
         #1 chk("reset_avail", stat_avail, 0);
      end

      // Basic allocation with header overhead.
      do_cfg(0, 0, 'h400000);
      do_alloc(0, 10, 1, 0);
      chk("alloc13", stat_avail, 13);

      // Exact fill then overflow on pool 1.
      do_cfg(1, 'h400000, 'h400010);
      do_alloc(1, 16, 0, 0);
      do_alloc(1, 1, 0, 0);

      // LIFO frees down to empty.
      do_cfg(0, 0, 'h400000);
      do_alloc(0, 5, 0, 0);
      do_alloc(0, 7, 0, 0);
      stat_pool = 0;
      #1 chk("avail12", stat_avail, 12);
      do_free();
      do_free();
      do_free();
      stat_pool = 0;
      #1 chk("avail0", stat_avail, 0);

      // Stack overflow drops the oldest entry.
      do_cfg(0, 0, 'h400000);
      do_alloc(0, $urandom_range(1, 50), 0, 0);
      first_end = m_av[0];
      for (int i = 0; i < 8; i++) do_alloc(0, $urandom_range(1, 50), $urandom_range(0, 1), 0);
      for (int i = 0; i < 9; i++) do_free();
      stat_pool = 0;
      #1 chk("avail_first_end", stat_avail, first_end);

      // Simultaneous cfg/free/request: only cfg wins.
      do_alloc(0, 4, 0, 0);
      @(negedge clk);
      cfg_we = 1'b1; cfg_pool = 0; cfg_base = 'h100; cfg_limit = 'h200;
      free_valid = 1'b1; req_valid = 1'b1; req_pool = 0; req_len = 4;
      #1 chk("simul_req_ready", req_ready, 0);
      @(negedge clk);
      cfg_we = 1'b0; free_valid = 1'b0; req_valid = 1'b0;
      m_lim[0] = 'h200; m_av[0] = 'h100; stk.delete();
      stat_pool = 0;
      #1 chk("simul_cfg", stat_avail, 'h100);
      chk("simul_no_free_err", free_err, 0);
      repeat (2) begin
         @(negedge clk);
         chk("simul_no_rsp", rsp_valid, 0);
      end
      do_free();
      do_alloc(0, 8, 1, 5);

      // Invalid pool and zero length.
      do_alloc(3, 5, 0, 0);
      do_alloc(0, 0, 0, 0);

      // Reset during CALC discards the request.
      @(negedge clk);
      req_valid = 1'b1; req_pool = 0; req_len = 2; req_hdr = 0;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1 check_reset_outputs("mid_rst");
      stat_pool = 0;
      #1 chk("mid_rst_avail", stat_avail, 0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", rsp_valid, 0);
      end

      // Random mix over all pools.
      for (int p = 0; p < NP; p++) begin
         b = $urandom_range(0, 'h1000) + p * 'h100000;
         do_cfg(p, b, b + $urandom_range(0, 300));
      end
      stk.delete();
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) do_free();
         else if (r == 9) do_alloc($urandom_range(0, 3), longint'($urandom), $urandom_range(0, 1), 0);
         else do_alloc($urandom_range(0, 3), $urandom_range(0, 60), $urandom_range(0, 1),
                       $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
